// File: rtl/spi_master_core.sv
// SPI master engine: runtime CPOL/CPHA, programmable SCLK half-period,
// MSB-first DATA_W-bit frames, one-hot active-low selects with optional SS hold.
module spi_master_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 3,
    parameter int unsigned DIV_W  = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    output logic                                    ready_o,
    output logic                                    busy_o,
    input  logic [DATA_W-1:0]                       tx_data_i,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel_i,
    input  logic                                    cpol_i,
    input  logic                                    cpha_i,
    input  logic [DIV_W-1:0]                        clk_div_i,
    input  logic                                    hold_ss_i,
    output logic [DATA_W-1:0]                       rx_data_o,
    output logic                                    rx_valid_o,
    output logic                                    err_o,
    output logic                                    SCLK_o,
    output logic                                    MOSI_o,
    input  logic                                    MISO_i,
    output logic [NUM_SS-1:0]                       SS_o
);

    localparam int unsigned SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LEADOUT, GAP} state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [EDGE_W-1:0]   r_edge;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [DATA_W-1:0]   r_rx;
    logic                r_rx_valid;
    logic                r_err;
    logic                r_ready;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_SS-1:0]   r_ss;
    logic [SEL_W-1:0]    r_sel;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_hold;
    logic                r_held;
    logic                r_pend;

    logic [EDGE_W-1:0]   w_edge_n;
    logic                w_sample;
    logic                w_shift;
    logic                w_sel_ok;
    logic [NUM_SS-1:0]   w_ss_new;
    logic [NUM_SS-1:0]   w_ss_lat;

    // w_edge_n is the SCLK edge number about to be produced (odd = leading edge)
    assign w_edge_n = r_edge + EDGE_W'(1);
    assign w_sample = r_cpha ? ~w_edge_n[0] : w_edge_n[0];
    assign w_shift  = r_cpha ? w_edge_n[0] : (~w_edge_n[0] && (w_edge_n != LAST_EDGE));
    assign w_sel_ok = (32'(ss_sel_i) < NUM_SS);
    assign w_ss_new = ~(NUM_SS'(1) << ss_sel_i);
    assign w_ss_lat = ~(NUM_SS'(1) << r_sel);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_edge     <= '0;
            r_tx       <= '0;
            r_rx_sh    <= '0;
            r_rx       <= '0;
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss       <= '1;
            r_sel      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_hold     <= 1'b0;
            r_held     <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !w_sel_ok) begin
                        r_err <= 1'b1;
                    end else if (start_i) begin
                        r_sel   <= ss_sel_i;
                        r_cpol  <= cpol_i;
                        r_cpha  <= cpha_i;
                        r_div   <= clk_div_i;
                        r_hold  <= hold_ss_i;
                        r_sclk  <= cpol_i;
                        r_cnt   <= clk_div_i;
                        r_edge  <= '0;
                        r_ready <= 1'b0;
                        r_held  <= 1'b0;
                        // Switching away from a held slave: release it and gap first
                        if (r_held && (ss_sel_i != r_sel)) begin
                            r_ss    <= '1;
                            r_tx    <= tx_data_i;
                            r_pend  <= 1'b1;
                            r_state <= GAP;
                        end else begin
                            r_ss    <= w_ss_new;
                            r_state <= SETUP;
                            if (cpha_i) begin
                                r_tx <= tx_data_i;
                            end else begin
                                r_mosi <= tx_data_i[DATA_W-1];
                                r_tx   <= tx_data_i << 1;
                            end
                        end
                    end
                end
                SETUP, SHIFT: begin
                    if (r_cnt == '0) begin
                        r_cnt  <= r_div;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_n;
                        if (w_sample) begin
                            r_rx_sh <= {r_rx_sh[DATA_W-2:0], MISO_i};
                        end
                        if (w_shift) begin
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= r_tx << 1;
                        end
                        r_state <= (w_edge_n == LAST_EDGE) ? LEADOUT : SHIFT;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                LEADOUT: begin
                    if (r_cnt == '0) begin
                        r_rx       <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        if (r_hold) begin
                            r_held  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ss    <= '1;
                            r_cnt   <= r_div;
                            r_pend  <= 1'b0;
                            r_state <= GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end else if (r_pend) begin
                        r_pend  <= 1'b0;
                        r_ss    <= w_ss_lat;
                        r_cnt   <= r_div;
                        r_state <= SETUP;
                        if (!r_cpha) begin
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= r_tx << 1;
                        end
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign busy_o     = ~r_ready;
    assign rx_data_o  = r_rx;
    assign rx_valid_o = r_rx_valid;
    assign err_o      = r_err;
    assign SCLK_o     = r_sclk;
    assign MOSI_o     = r_mosi;
    assign SS_o       = r_ss;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: modes 0/3, SS hold, slave switch,
// busy-start rejection, mid-frame reset and invalid-slave error.
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx = 8'h00;
    logic [1:0] sel = 2'd0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] div = 8'd0;
    logic       hold = 1'b0;

    logic       ready_o, busy_o, rx_valid_o, err_o, SCLK_o, MOSI_o;
    logic [7:0] rx_data_o;
    logic [2:0] SS_o;
    logic       w_miso;

    logic       loop_en = 1'b1;
    logic       miso_s = 1'b0;
    logic       slv_en = 1'b0;
    logic [7:0] slv_tx = 8'h3C;
    logic [7:0] slv_cap = 8'h00;
    int         slv_di = 0;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       ok;

    assign w_miso = loop_en ? MOSI_o : miso_s;

    spi_master_core dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .tx_data_i  (tx),
        .ss_sel_i   (sel),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .clk_div_i  (div),
        .hold_ss_i  (hold),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .err_o      (err_o),
        .SCLK_o     (SCLK_o),
        .MOSI_o     (MOSI_o),
        .MISO_i     (w_miso),
        .SS_o       (SS_o)
    );

    always #5 clk = ~clk;

    // Mode-3 slave: drives on leading (falling) edge, captures on trailing (rising) edge
    always @(negedge SCLK_o) begin
        if (slv_en && slv_di < 8) begin
            miso_s = slv_tx[7 - slv_di];
            slv_di = slv_di + 1;
        end
    end

    always @(posedge SCLK_o) begin
        if (slv_en) slv_cap = {slv_cap[6:0], MOSI_o};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    // Called 1 time unit after a rising edge; returns in cycle 1 of the new request
    task automatic launch(input logic [7:0] t, input logic [1:0] s, input logic p,
                          input logic h, input logic [7:0] d, input logic hs);
        tx = t; sel = s; cpol = p; cpha = h; div = d; hold = hs;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk",  32'(SCLK_o), 0);
        check("rst_mosi",  32'(MOSI_o), 0);
        check("rst_ss",    32'(SS_o), 'h7);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_busy",  32'(busy_o), 0);
        check("rst_rx",    32'(rx_data_o), 0);
        check("rst_valid", 32'(rx_valid_o), 0);
        check("rst_err",   32'(err_o), 0);
        rst = 1'b0;
        step();

        // 1: mode 0, H=2, loopback 0xA5 on slave 0
        launch(8'hA5, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0);
        check("t1_ss_c1",   32'(SS_o), 'h6);
        check("t1_mosi_c1", 32'(MOSI_o), 1);
        check("t1_busy_c1", 32'(busy_o), 1);
        goto(2);
        check("t1_sclk_c2", 32'(SCLK_o), 0);
        goto(3);
        check("t1_sclk_c3", 32'(SCLK_o), 1);
        ok = 1'b1;
        while (cyc < 35) begin
            if (SS_o !== 3'b110 || rx_valid_o !== 1'b0) ok = 1'b0;
            step();
        end
        check("t1_ss_frame", 32'(ok), 1);
        check("t1_valid_c35", 32'(rx_valid_o), 1);
        check("t1_rx_c35",    32'(rx_data_o), 'hA5);
        check("t1_ss_c35",    32'(SS_o), 'h7);
        check("t1_ready_c35", 32'(ready_o), 0);
        step();
        check("t1_valid_c36", 32'(rx_valid_o), 0);
        check("t1_ready_c36", 32'(ready_o), 0);
        step();
        check("t1_ready_c37", 32'(ready_o), 1);
        check("t1_busy_c37",  32'(busy_o), 0);

        // 2: mode 3, slave model returns 0x3C, master sends 0x9F to slave 2
        loop_en = 1'b0;
        launch(8'h9F, 2'd2, 1'b1, 1'b1, 8'd1, 1'b0);
        slv_en = 1'b1;
        check("t2_sclk_c1", 32'(SCLK_o), 1);
        check("t2_ss_c1",   32'(SS_o), 'h3);
        ok = 1'b1;
        while (cyc < 35) begin
            if (SS_o !== 3'b011) ok = 1'b0;
            step();
        end
        check("t2_ss_frame", 32'(ok), 1);
        check("t2_valid",    32'(rx_valid_o), 1);
        check("t2_rx",       32'(rx_data_o), 'h3C);
        check("t2_slv_cap",  32'(slv_cap), 'h9F);
        check("t2_sclk_idle", 32'(SCLK_o), 1);
        goto(37);
        check("t2_ready", 32'(ready_o), 1);
        slv_en = 1'b0;
        loop_en = 1'b1;

        // 3: held frame 0x03 then releasing frame 0x00 on slave 2, H=1
        launch(8'h03, 2'd2, 1'b0, 1'b0, 8'd0, 1'b1);
        ok = 1'b1;
        while (cyc < 18) begin
            if (SS_o !== 3'b011) ok = 1'b0;
            step();
        end
        check("t3a_ss_frame", 32'(ok), 1);
        check("t3a_valid",    32'(rx_valid_o), 1);
        check("t3a_rx",       32'(rx_data_o), 'h03);
        check("t3a_ready",    32'(ready_o), 1);
        check("t3a_ss_end",   32'(SS_o), 'h3);
        ok = 1'b1;
        while (cyc < 23) begin
            step();
            if (SS_o !== 3'b011 || ready_o !== 1'b1) ok = 1'b0;
        end
        check("t3_ss_held_idle", 32'(ok), 1);
        launch(8'h00, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
        ok = 1'b1;
        while (cyc < 18) begin
            if (SS_o !== 3'b011) ok = 1'b0;
            step();
        end
        check("t3b_ss_frame", 32'(ok), 1);
        check("t3b_valid",    32'(rx_valid_o), 1);
        check("t3b_rx",       32'(rx_data_o), 'h00);
        check("t3b_ss_end",   32'(SS_o), 'h7);
        step();
        check("t3b_ready", 32'(ready_o), 1);

        // 4: held on slave 0, follow-up to slave 1 with H=2
        launch(8'h5A, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1);
        goto(35);
        check("t4a_valid", 32'(rx_valid_o), 1);
        check("t4a_rx",    32'(rx_data_o), 'h5A);
        check("t4a_ready", 32'(ready_o), 1);
        check("t4a_ss",    32'(SS_o), 'h6);
        step();
        launch(8'h81, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
        check("t4_ss_c1",   32'(SS_o), 'h7);
        check("t4_mosi_c1", 32'(MOSI_o), 0);
        step();
        check("t4_ss_c2", 32'(SS_o), 'h7);
        step();
        check("t4_ss_c3",   32'(SS_o), 'h5);
        check("t4_mosi_c3", 32'(MOSI_o), 1);
        ok = 1'b1;
        while (cyc < 37) begin
            if (SS_o !== 3'b101 || (SS_o[0] === 1'b0 && SS_o[1] === 1'b0)) ok = 1'b0;
            step();
        end
        check("t4_ss_frame", 32'(ok), 1);
        check("t4b_valid",   32'(rx_valid_o), 1);
        check("t4b_rx",      32'(rx_data_o), 'h81);
        goto(39);
        check("t4b_ready", 32'(ready_o), 1);

        // 5: start while busy is ignored; H=1 timing
        launch(8'hC3, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
        goto(3);
        tx = 8'h3C; sel = 2'd0; div = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("t5_err_c4", 32'(err_o), 0);
        check("t5_ss_c4",  32'(SS_o), 'h5);
        goto(17);
        check("t5_valid_c17", 32'(rx_valid_o), 0);
        step();
        check("t5_valid_c18", 32'(rx_valid_o), 1);
        check("t5_rx",        32'(rx_data_o), 'hC3);
        step();
        check("t5_ready_c19", 32'(ready_o), 1);

        // 6: reset at SCLK edge 5, then invalid slave request
        launch(8'hFF, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0);
        goto(11);
        check("t6_sclk_e5", 32'(SCLK_o), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_sclk",  32'(SCLK_o), 0);
        check("t6_rst_mosi",  32'(MOSI_o), 0);
        check("t6_rst_ss",    32'(SS_o), 'h7);
        check("t6_rst_ready", 32'(ready_o), 1);
        check("t6_rst_busy",  32'(busy_o), 0);
        check("t6_rst_rx",    32'(rx_data_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rx_valid_o !== 1'b0 || SS_o !== 3'b111) ok = 1'b0;
        end
        check("t6_no_valid", 32'(ok), 1);
        launch(8'h55, 2'd3, 1'b0, 1'b0, 8'd1, 1'b0);
        check("t6_err_c1",   32'(err_o), 1);
        check("t6_ss_c1",    32'(SS_o), 'h7);
        check("t6_ready_c1", 32'(ready_o), 1);
        step();
        check("t6_err_c2",   32'(err_o), 0);
        check("t6_ready_c2", 32'(ready_o), 1);
        check("t6_ss_c2",    32'(SS_o), 'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
Parametrised SPI master engine. Replaces the fixed-mode, fixed-slave transceiver with one that has:
- runtime-selectable CPOL/CPHA;
- a programmable SCLK divider;
- DATA_W-bit MSB-first frames;
- NUM_SS one-hot active-low selects;
- optional chip-select hold for multi-frame commands (W25Q16 read/fast-read, MPU6000 burst, 74HC595 chains).

It sits between the board controller FSM and the pads.

Parameters:
DATA_W, 8, frame width in bits (2..32)
NUM_SS, 3, number of slave-select lines
DIV_W, 8, width of clock-divider input

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  transfer request, accepted only when ready_o=1
ready_o  out  1  core idle, can accept start_i
busy_o  out  1  inverse of ready_o
tx_data_i  in  DATA_W  frame to transmit
ss_sel_i  in  $clog2(NUM_SS)  slave index
cpol_i  in  1  SCLK idle level
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
clk_div_i  in  DIV_W  half-period H = clk_div_i+1 clk cycles
hold_ss_i  in  1  keep SS asserted after this frame
rx_data_o  out  DATA_W  last received frame
rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
err_o  out  1  one-cycle pulse, start with ss_sel_i >= NUM_SS
SCLK_o  out  1  serial clock
MOSI_o  out  1  master out
MISO_i  in  1  master in
SS_o  out  NUM_SS  active-low selects

Behaviour:
- Reset values:
  - SCLK_o=0, MOSI_o=0, SS_o=all 1s;
  - ready_o=1, busy_o=0;
  - rx_data_o=0, rx_valid_o=0, err_o=0;
  - state IDLE.
- Reset mid-transfer aborts immediately. Same reset values; no rx_valid_o.
- States: IDLE, SETUP, SHIFT, LEADOUT, GAP.
- Start acceptance (cycle 0):
  - start_i accepted when ready_o=1.
  - Latch tx_data_i, ss_sel_i, cpol_i, cpha_i, clk_div_i, hold_ss_i.
  - start_i while busy is ignored (no latch, no error).
- Invalid slave: if ss_sel_i >= NUM_SS at start, err_o pulses at cycle 1, no transfer, ready_o stays 1.
- SETUP:
  - Cycle 1: SS_o[sel]=0, SCLK_o=cpol; SETUP lasts H cycles.
  - CPHA=0: MOSI_o=tx MSB from cycle 1.
- SHIFT:
  - SCLK edge k (k=1..2*DATA_W) toggles at cycle k*H+1.
  - CPHA=0: MISO sampled on odd edges; MOSI shifts to next bit on even edges (except the last).
  - CPHA=1: MOSI shifts on odd edges (first odd edge drives MSB); MISO sampled on even edges.
  - MISO sampled directly, no extra sync stage.
- LEADOUT:
  - H cycles after the last edge. SCLK_o=cpol.
  - At cycle (2*DATA_W+1)*H+1: rx_data_o updated and rx_valid_o=1 for one cycle.
- Frame end, hold_ss latched=1: SS stays low; enter IDLE; ready_o=1 in the same cycle as rx_valid_o.
- Frame end, hold_ss latched=0:
  - SS_o all high in the same cycle as rx_valid_o.
  - GAP lasts H cycles.
  - ready_o=1 at cycle (2*DATA_W+2)*H+1.
- Held-SS follow-up start:
  - Same slave: SETUP re-entered with SS kept low.
  - Different slave: held SS deasserted at cycle 1, GAP of H cycles, then SETUP on the new slave with its SS low.
- Idle with held SS: SS_o stays asserted indefinitely. Released only by a frame with hold_ss_i=0, or by reset.
- Idle lines: MOSI_o holds its last value; SCLK_o=latched cpol.
- Mode/divider inputs are ignored outside the start cycle.
- Divider counter: DIV_W bits. clk_div_i=0 gives H=1 (SCLK = clk/2). Maximum H=2^DIV_W.

Test Plan:
1. Mode 0, DATA_W=8, clk_div_i=1, MISO looped to MOSI, tx 0xA5 -> rx_valid_o at cycle 35 with rx_data_o=0xA5; ready_o back at cycle 37; SS_o=3'b110 for sel=0 during cycles 1..34.
2. Mode 3 (cpol=1, cpha=1), slave model returning 0x3C, tx 0x9F, sel=2 -> SCLK idles high; model captures 0x9F; rx_data_o=0x3C; SS_o=3'b011 during the frame.
3. hold_ss_i=1 frame 0x03 then hold_ss_i=0 frame 0x00 to sel=2 -> SS_o[2] low continuously across both frames; two rx_valid_o pulses; SS_o[2] high only after the second.
4. Held SS on sel=0, next start on sel=1 -> SS_o[0] rises at cycle 1; SS_o[1] falls after H cycles; no cycle with both low.
5. start_i pulsed while busy with different tx_data_i, plus clk_div_i=0 -> second request ignored; H=1 timing: rx_valid_o at cycle 18.
6. rst_i asserted at edge 5 of a frame -> outputs at reset values immediately; no rx_valid_o. Then start with ss_sel_i=3 -> err_o pulse at cycle 1 and SS_o stays 3'b111.
